// File: rtl/gray8_stream_source.sv
// Synthetic 8-bit grayscale video source: frame/line timing FSM plus selectable
// test patterns, driving the same wr_en/img_Y/pre_href interface as the camera path.
module gray8_stream_source #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 16,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       enable,
  input  logic       pix_ce,
  input  logic [1:0] pattern_sel,
  output logic       vsync,
  output logic       pre_href,
  output logic       wr_en,
  output logic [7:0] img_Y,
  output logic       frame_done,
  output logic       busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned V_MAX_A = (V_SYNC > V_BP) ? V_SYNC : V_BP;
  localparam int unsigned V_MAX_B = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
  localparam int unsigned V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int unsigned VW      = $clog2(V_MAX + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_BP     = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_FP     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [VW-1:0] v_last;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [1:0]    pat_q, pat_d;
  logic          frame_end;

  logic          vsync_q, vsync_d;
  logic          pre_href_q, pre_href_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    img_q, img_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;

  logic [7:0]    x8, y8, pix;

  // Last line index of the current vertical region
  always_comb begin
    v_last = '0;
    case (state_q)
      ST_SYNC:   v_last = VW'(V_SYNC - 1);
      ST_BP:     v_last = VW'(V_BP - 1);
      ST_ACTIVE: v_last = VW'(V_ACTIVE - 1);
      ST_FP:     v_last = VW'(V_FP - 1);
      default:   v_last = '0;
    endcase
  end

  // Frame/line sequencing; everything advances only on pix_ce
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pat_d       = pat_q;
    frame_end   = 1'b0;
    if (pix_ce) begin
      if (state_q == ST_IDLE) begin
        if (enable) begin
          state_d = ST_SYNC;
          pat_d   = pattern_sel;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end
      end else if (h_cnt_q != H_LAST) begin
        h_cnt_d = h_cnt_q + HW'(1);
      end else begin
        h_cnt_d = '0;
        if (v_cnt_q != v_last) begin
          v_cnt_d = v_cnt_q + VW'(1);
        end else begin
          v_cnt_d = '0;
          case (state_q)
            ST_SYNC:   state_d = ST_BP;
            ST_BP:     state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_FP;
            default: begin
              frame_end   = 1'b1;
              frame_cnt_d = frame_cnt_q + 8'd1;
              if (enable) begin
                state_d = ST_SYNC;
                pat_d   = pattern_sel;
              end else begin
                state_d = ST_IDLE;
              end
            end
          endcase
        end
      end
    end
  end

  // Pattern generator, evaluated on the post-advance pixel position
  always_comb begin
    x8  = 8'(h_cnt_d);
    y8  = 8'(v_cnt_d);
    pix = 8'h00;
    case (pat_q)
      2'd0:    pix = x8;
      2'd1:    pix = y8;
      2'd2:    pix = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
      default: pix = frame_cnt_q;
    endcase
  end

  always_comb begin
    vsync_d      = (state_d == ST_SYNC);
    pre_href_d   = (state_d == ST_ACTIVE) && (h_cnt_d < H_ACT);
    wr_en_d      = pix_ce && pre_href_d;
    img_d        = wr_en_d ? pix : img_q;
    frame_done_d = frame_end;
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      frame_cnt_q  <= '0;
      pat_q        <= '0;
      vsync_q      <= 1'b0;
      pre_href_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      img_q        <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      pat_q        <= pat_d;
      vsync_q      <= vsync_d;
      pre_href_q   <= pre_href_d;
      wr_en_q      <= wr_en_d;
      img_q        <= img_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign vsync      = vsync_q;
  assign pre_href   = pre_href_q;
  assign wr_en      = wr_en_q;
  assign img_Y      = img_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gray8_stream_source.sv
// Bench for gray8_stream_source: two instances (small timing and 16x16 active area)
// checked against a pixel-index reference model, plus directed segment totals.
module tb_gray8_stream_source;

  typedef struct packed {
    int ha; int hb; int vs; int vb; int va; int vf;
  } cfg_t;

  typedef struct packed {
    logic       run;
    int         p;
    logic [7:0] fcnt;
    logic [1:0] pat;
    logic       vsync;
    logic       href;
    logic       wr;
    logic       fd;
    logic       busy;
    logic [7:0] img;
  } mdl_t;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [1:0] sel;
    int         ce_div;
    int         n;
    int         exp_wr;
    int         exp_fd;
    int         exp_href;
    logic       exp_busy;
    logic [7:0] exp_img;
  } seg_t;

  localparam cfg_t CFG0 = '{ha: 8,  hb: 4, vs: 1, vb: 1, va: 4,  vf: 1};
  localparam cfg_t CFG1 = '{ha: 16, hb: 4, vs: 1, vb: 1, va: 16, vf: 1};
  localparam int NSEG = 14;

  logic       clk = 1'b0;
  logic       rst, en, ce;
  logic [1:0] sel;

  logic       s_vsync, s_href, s_wr, s_fd, s_busy;
  logic [7:0] s_img;
  logic       c_vsync, c_href, c_wr, c_fd, c_busy;
  logic [7:0] c_img;

  mdl_t m0, m1;
  seg_t tbl [NSEG];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  gray8_stream_source #(
    .H_ACTIVE(8), .H_BLANK(4), .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1)
  ) u_dut (
    .sys_clk(clk), .sys_rst(rst), .enable(en), .pix_ce(ce), .pattern_sel(sel),
    .vsync(s_vsync), .pre_href(s_href), .wr_en(s_wr), .img_Y(s_img),
    .frame_done(s_fd), .busy(s_busy)
  );

  gray8_stream_source #(
    .H_ACTIVE(16), .H_BLANK(4), .V_SYNC(1), .V_BP(1), .V_ACTIVE(16), .V_FP(1)
  ) u_chk (
    .sys_clk(clk), .sys_rst(rst), .enable(en), .pix_ce(ce), .pattern_sel(sel),
    .vsync(c_vsync), .pre_href(c_href), .wr_en(c_wr), .img_Y(c_img),
    .frame_done(c_fd), .busy(c_busy)
  );

  // Model: position is a flat pixel index within the frame; regions follow from line number
  function automatic mdl_t mdl_step(mdl_t m, cfg_t c, logic e, logic pce, logic [1:0] s);
    mdl_t n;
    int ht, flen, line, x, y;
    n    = m;
    ht   = c.ha + c.hb;
    flen = ht * (c.vs + c.vb + c.va + c.vf);
    n.wr = 1'b0;
    n.fd = 1'b0;
    if (pce) begin
      if (!m.run) begin
        if (e) begin n.run = 1'b1; n.p = 0; n.pat = s; end
      end else if (m.p == flen - 1) begin
        n.fd   = 1'b1;
        n.fcnt = m.fcnt + 8'd1;
        if (e) begin n.p = 0; n.pat = s; end
        else n.run = 1'b0;
      end else begin
        n.p = m.p + 1;
      end
    end
    line    = n.p / ht;
    x       = n.p % ht;
    y       = line - (c.vs + c.vb);
    n.vsync = n.run && (line < c.vs);
    n.href  = n.run && (y >= 0) && (y < c.va) && (x < c.ha);
    n.busy  = n.run;
    n.wr    = pce && n.href;
    if (n.wr) begin
      case (n.pat)
        2'd0:    n.img = 8'(x);
        2'd1:    n.img = 8'(y);
        2'd2:    n.img = (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
        default: n.img = n.fcnt;
      endcase
    end
    return n;
  endfunction

  function automatic logic [12:0] pack(mdl_t m);
    return {m.vsync, m.href, m.wr, m.fd, m.busy, m.img};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_outs(input string tag);
    chk({tag, "_small"}, 32'({s_vsync, s_href, s_wr, s_fd, s_busy, s_img}), 32'(pack(m0)));
    chk({tag, "_16x16"}, 32'({c_vsync, c_href, c_wr, c_fd, c_busy, c_img}), 32'(pack(m1)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m0 = '0;
      m1 = '0;
    end else begin
      m0 = mdl_step(m0, CFG0, en, ce, sel);
      m1 = mdl_step(m1, CFG1, en, ce, sel);
    end
    #1;
    cmp_outs("cyc");
  endtask

  // Reset is asserted between edges: outputs must clear without waiting for a clock
  task automatic assert_rst();
    rst = 1'b1;
    #1;
    m0 = '0;
    m1 = '0;
    cmp_outs("async_rst");
  endtask

  initial begin
    int n_wr, n_fd, n_href, n_px, n_ff;
    rst = 1'b0; en = 1'b0; ce = 1'b0; sel = 2'd0;
    m0 = '0; m1 = '0;

    //            rst   en    sel   div  n    wr  fd href busy  img
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 1,   3,   0,  0, 0,  1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 2'd0, 1,   85,  32, 1, 32, 1'b1, 8'h07};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 1,   2,   0,  0, 0,  1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 2'd3, 1,   253, 96, 3, 96, 1'b1, 8'h02};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 1,   2,   0,  0, 0,  1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 2'd1, 3,   252, 32, 0, 96, 1'b1, 8'h03};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 1,   2,   0,  0, 0,  1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b1, 2'd0, 1,   28,  4,  0, 4,  1'b1, 8'h03};
    tbl[8]  = '{1'b1, 1'b1, 2'd0, 1,   2,   0,  0, 0,  1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 2'd0, 1,   85,  32, 1, 32, 1'b1, 8'h07};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 1,   2,   0,  0, 0,  1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 2'd2, 1,   17,  0,  0, 0,  1'b1, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 1,   68,  32, 1, 32, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 1'b0, 2'd1, 1,   10,  0,  0, 0,  1'b0, 8'h00};

    for (int s = 0; s < NSEG; s++) begin
      n_wr = 0; n_fd = 0; n_href = 0;
      if (tbl[s].rst) assert_rst();
      else rst = 1'b0;
      en  = tbl[s].en;
      sel = tbl[s].sel;
      for (int k = 0; k < tbl[s].n; k++) begin
        ce = ((k % tbl[s].ce_div) == 0);
        tick();
        if (s_wr)   n_wr++;
        if (s_fd)   n_fd++;
        if (s_href) n_href++;
      end
      chk($sformatf("seg%0d_wr_pulses", s), 32'(n_wr), 32'(tbl[s].exp_wr));
      chk($sformatf("seg%0d_frame_done", s), 32'(n_fd), 32'(tbl[s].exp_fd));
      chk($sformatf("seg%0d_href_clks", s), 32'(n_href), 32'(tbl[s].exp_href));
      chk($sformatf("seg%0d_busy", s), 32'(s_busy), 32'(tbl[s].exp_busy));
      chk($sformatf("seg%0d_img", s), 32'(s_img), 32'(tbl[s].exp_img));
    end

    // 16x16 checkerboard quadrants on the larger instance
    assert_rst();
    tick();
    rst = 1'b0; en = 1'b1; sel = 2'd2; ce = 1'b1;
    n_px = 0; n_ff = 0; n_fd = 0;
    for (int k = 0; k < 381; k++) begin
      tick();
      if (c_wr) begin
        if (n_px == 0)   chk("chk_x0_y0", 32'(c_img), 32'h00);
        if (n_px == 8)   chk("chk_x8_y0", 32'(c_img), 32'hFF);
        if (n_px == 128) chk("chk_x0_y8", 32'(c_img), 32'hFF);
        if (n_px == 136) chk("chk_x8_y8", 32'(c_img), 32'h00);
        if (c_img == 8'hFF) n_ff++;
        n_px++;
      end
      if (c_fd) n_fd++;
    end
    chk("chk_pixels", 32'(n_px), 32'd256);
    chk("chk_white", 32'(n_ff), 32'd128);
    chk("chk_frame_done", 32'(n_fd), 32'd1);

    // Random enable/pix_ce/pattern traffic with occasional resets
    en = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      if ($urandom_range(0, 249) == 0) en = ~en;
      ce  = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1999) == 0) assert_rst();
      else rst = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
